// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code position sequencer.
package gray_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_pos_core.sv
// Binary position register with wrap compare and registered Gray encode.
module gray_pos_core
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] gray,
  output logic             wrapped
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q;
  logic             at_lim;

  // >= so a position left above a smaller new limit wraps too
  always_comb begin
    at_lim = (bin_q >= limit);
    bin_d  = bin_q;
    if (adv) begin
      bin_d = at_lim ? '0 : bin_q + 1'b1;
    end
    gray_d = WIDTH'(bin2gray(16'(bin_d)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= adv & at_lim;
    end
  end

  assign gray    = gray_q;
  assign wrapped = wrap_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Run controller: FSM, prescaler and step counter driving gray_pos_core.
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH+3:0] cfg_len,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [7:0]       cfg_div,
  input  logic             cfg_cont,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             step,
  output logic             wrap,
  output logic [WIDTH-1:0] gray
);

  state_e           state_q, state_d;
  logic [7:0]       presc_q, presc_d;
  logic [WIDTH+3:0] rem_q, rem_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [7:0]       div_q, div_d;
  logic             cont_q, cont_d;
  logic             abort_q, abort_d;
  logic             step_q;
  logic             adv;
  logic             tick;

  assign tick = (presc_q == div_q);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    lim_d   = lim_q;
    div_d   = div_q;
    cont_d  = cont_q;
    abort_d = abort_q;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lim_d   = cfg_limit;
          div_d   = cfg_div;
          cont_d  = cfg_cont;
          rem_d   = cfg_len;
          presc_d = '0;
          abort_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (!cont_q && rem_q == '0) begin
          state_d = S_DONE;
        end else if (tick) begin
          adv     = 1'b1;
          presc_d = '0;
          if (!cont_q) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == (WIDTH+4)'(1)) begin
              state_d = S_DONE;
            end
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      lim_q   <= '0;
      div_q   <= '0;
      cont_q  <= 1'b0;
      abort_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      lim_q   <= lim_d;
      div_q   <= div_d;
      cont_q  <= cont_d;
      abort_q <= abort_d;
      step_q  <= adv;
    end
  end

  gray_pos_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .adv    (adv),
    .limit  (lim_q),
    .gray   (gray),
    .wrapped(wrap)
  );

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign aborted = abort_q;
  assign step    = step_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl (WIDTH=4).
module tb_gray_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, stop, cfg_cont;
  logic [W+3:0] cfg_len;
  logic [W-1:0] cfg_limit;
  logic [7:0]   cfg_div;
  logic         busy, done, aborted, step, wrap;
  logic [W-1:0] gray;
  logic [4:0]   fl;

  int total = 0;
  int bad   = 0;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .cfg_len  (cfg_len),
    .cfg_limit(cfg_limit),
    .cfg_div  (cfg_div),
    .cfg_cont (cfg_cont),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .step     (step),
    .wrap     (wrap),
    .gray     (gray)
  );

  always #5 clk = ~clk;

  // flags packed as {busy,done,aborted,step,wrap}
  assign fl = {busy, done, aborted, step, wrap};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; stop = 1'b0;
    cfg_len = 8'd3; cfg_limit = 4'd15; cfg_div = 8'd0; cfg_cont = 1'b0;
    cyc(); cyc();
    total++;
    if (fl !== 5'b00000) begin
      bad++; $display("FAIL rst_flags got=%b want=%b", fl, 5'b00000);
    end
    total++;
    if (gray !== 4'd0) begin
      bad++; $display("FAIL rst_gray got=%0d want=0", gray);
    end
    reset = 1'b0; start = 1'b0;
    cyc();
    total++;
    if (fl !== 5'b00000) begin
      bad++; $display("FAIL rst_idle got=%b want=%b", fl, 5'b00000);
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] eg [5] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7};
    logic [4:0] ef;
    cfg_div = 8'd0; cfg_limit = 4'd15; cfg_len = 8'd5; cfg_cont = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    total++;
    if (fl !== 5'b10000 || gray !== 4'd0) begin
      bad++; $display("FAIL os_accept got=%b/%0d want=10000/0", fl, gray);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      ef = (i == 4) ? 5'b01010 : 5'b10010;
      total++;
      if (gray !== eg[i]) begin
        bad++; $display("FAIL os_gray[%0d] got=%0d want=%0d", i, gray, eg[i]);
      end
      total++;
      if (fl !== ef) begin
        bad++; $display("FAIL os_flags[%0d] got=%b want=%b", i, fl, ef);
      end
    end
    cyc();
    total++;
    if (fl !== 5'b00000 || gray !== 4'd7) begin
      bad++; $display("FAIL os_idle got=%b/%0d want=00000/7", fl, gray);
    end
  endtask

  task automatic test_div();
    logic [4:0] ef;
    logic [3:0] eg;
    cfg_div = 8'd2; cfg_limit = 4'd15; cfg_len = 8'd2; cfg_cont = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    total++;
    if (fl !== 5'b10000) begin
      bad++; $display("FAIL div_accept got=%b want=10000", fl);
    end
    for (int c = 1; c <= 6; c++) begin
      cyc();
      ef = {c < 6, c == 6, 1'b0, (c == 3 || c == 6), 1'b0};
      eg = (c < 3) ? 4'd7 : (c < 6) ? 4'd5 : 4'd4;
      total++;
      if (fl !== ef || gray !== eg) begin
        bad++;
        $display("FAIL div_c%0d got=%b/%0d want=%b/%0d", c, fl, gray, ef, eg);
      end
    end
    cyc();
  endtask

  task automatic test_wrap_cont();
    logic [3:0] eg [8] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd0, 4'd1};
    logic [4:0] ef;
    cfg_div = 8'd0; cfg_limit = 4'd5; cfg_len = 8'd1; cfg_cont = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1; cfg_limit = 4'd15; cfg_cont = 1'b0; cfg_div = 8'd3;
      end
      if (i == 5) start = 1'b0;
      cyc();
      ef = {3'b100, 1'b1, (i == 0 || i == 6)};
      total++;
      if (gray !== eg[i] || fl !== ef) begin
        bad++;
        $display("FAIL wc[%0d] got=%b/%0d want=%b/%0d", i, fl, gray, ef, eg[i]);
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total++;
    if (fl !== 5'b01100 || gray !== 4'd1) begin
      bad++; $display("FAIL wc_stop got=%b/%0d want=01100/1", fl, gray);
    end
    cyc();
    total++;
    if (fl !== 5'b00100 || gray !== 4'd1) begin
      bad++; $display("FAIL wc_hold got=%b/%0d want=00100/1", fl, gray);
    end
  endtask

  task automatic test_stop_tick();
    cfg_div = 8'd1; cfg_limit = 4'd15; cfg_cont = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    total++;
    if (fl !== 5'b10000) begin
      bad++; $display("FAIL st_accept got=%b want=10000", fl);
    end
    cyc();
    total++;
    if (fl !== 5'b10000 || gray !== 4'd1) begin
      bad++; $display("FAIL st_pre got=%b/%0d want=10000/1", fl, gray);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total++;
    if (fl !== 5'b01100 || gray !== 4'd1) begin
      bad++; $display("FAIL st_abort got=%b/%0d want=01100/1", fl, gray);
    end
    cyc();
    stop = 1'b1;
    cyc();
    total++;
    if (fl !== 5'b00100) begin
      bad++; $display("FAIL st_idle_stop got=%b want=00100", fl);
    end
  endtask

  task automatic test_start_stop_idle();
    cfg_div = 8'd0; cfg_limit = 4'd15; cfg_len = 8'd1; cfg_cont = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    total++;
    if (fl !== 5'b10000) begin
      bad++; $display("FAIL ss_accept got=%b want=10000", fl);
    end
    cyc();
    total++;
    if (fl !== 5'b01010 || gray !== 4'd3) begin
      bad++; $display("FAIL ss_done got=%b/%0d want=01010/3", fl, gray);
    end
    cyc();
  endtask

  task automatic test_len0();
    cfg_len = 8'd0; cfg_cont = 1'b0; cfg_div = 8'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    total++;
    if (fl !== 5'b10000) begin
      bad++; $display("FAIL l0_run got=%b want=10000", fl);
    end
    cyc();
    total++;
    if (fl !== 5'b01000 || gray !== 4'd3) begin
      bad++; $display("FAIL l0_done got=%b/%0d want=01000/3", fl, gray);
    end
    cyc();
    total++;
    if (fl !== 5'b00000) begin
      bad++; $display("FAIL l0_idle got=%b want=00000", fl);
    end
  endtask

  task automatic test_reset_mid();
    cfg_div = 8'd0; cfg_limit = 4'd15; cfg_cont = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    total++;
    if (fl !== 5'b10010 || gray !== 4'd13) begin
      bad++; $display("FAIL rm_pos9 got=%b/%0d want=10010/13", fl, gray);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if (fl !== 5'b00000 || gray !== 4'd0) begin
      bad++; $display("FAIL rm_reset got=%b/%0d want=00000/0", fl, gray);
    end
    cyc();
    total++;
    if (fl !== 5'b00000) begin
      bad++; $display("FAIL rm_nodone got=%b want=00000", fl);
    end
  endtask

  task automatic test_limit0();
    logic [4:0] ef;
    cfg_div = 8'd0; cfg_limit = 4'd0; cfg_len = 8'd3; cfg_cont = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      ef = (i == 2) ? 5'b01011 : 5'b10011;
      total++;
      if (fl !== ef || gray !== 4'd0) begin
        bad++; $display("FAIL lz[%0d] got=%b/%0d want=%b/0", i, fl, gray, ef);
      end
    end
    cyc();
    total++;
    if (fl !== 5'b00000) begin
      bad++; $display("FAIL lz_idle got=%b want=00000", fl);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_div();
    test_wrap_cont();
    test_stop_tick();
    test_start_stop_idle();
    test_len0();
    test_reset_mid();
    test_limit0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
